frame_update_scheduler: RTL and testbench

//  Round-robin scheduler that shares the per-frame update window (vblank) between game-logic

---
 rtl/frame_update_scheduler.sv | 135 +++++++++++++
 tb/tb_frame_update_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
//   Round-robin scheduler for the per-frame update window. A frame-start pulse
//   snapshots the pending requests; each snapshotted requester then gets one
//   registered one-hot grant, held until its done bit or a timeout, and a
//   frame-done pulse closes the frame. The round-robin pointer carries over
//   between frames so service order rotates fairly.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   frame_start_i  1-cycle vblank start pulse
//   req_i          level requests, sampled only when a frame start is accepted
//   done_i         completion strobes, only the current grantee's bit counts
//   grant_o        registered one-hot (or zero) grant
//   busy_o         scheduler is not idle
//   frame_done_o   1-cycle pulse once the snapshot has been fully served
//   timeout_o      1-cycle pulse, coincident with a forced release
//   overrun_o      1-cycle pulse, one cycle after a frame start seen while busy
module frame_update_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TW             = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] done_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               timeout_o,
    output logic               overrun_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_FINISH} state_t;

    state_t             r_state, w_next;
    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_grant;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      r_gidx;
    logic [TW-1:0]      r_cnt;
    logic               r_timeout;
    logic               r_overrun;

    logic               w_found;
    logic [PW-1:0]      w_sel;
    logic [NUM_REQ-1:0] w_sel_oh;
    logic               w_done_hit;
    logic               w_release;

    // First pending bit at or after rr_ptr. NUM_REQ is a power of two, so the
    // PW-bit index addition wraps modulo NUM_REQ for free.
    always_comb begin : arb
        logic [PW-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = r_rr_ptr + PW'(i);
            if (!w_found && r_pending[v_idx]) begin
                w_found = 1'b1;
                w_sel   = v_idx;
            end
        end
    end

    assign w_sel_oh   = NUM_REQ'(1) << w_sel;
    assign w_done_hit = done_i[r_gidx];
    // Done wins over a simultaneous timeout.
    assign w_release  = (r_state == S_GRANT) &&
                        (w_done_hit || (r_cnt == TW'(TIMEOUT_CYCLES - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (frame_start_i) w_next = S_ARB;
            S_ARB:    w_next = w_found ? S_GRANT : S_FINISH;
            S_GRANT:  if (w_release) w_next = S_ARB;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_gidx    <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            // A frame start while busy is dropped; FINISH counts as busy.
            r_overrun <= frame_start_i && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (frame_start_i) r_pending <= req_i;
                end
                S_ARB: begin
                    if (w_found) begin
                        r_grant <= w_sel_oh;
                        r_gidx  <= w_sel;
                        r_cnt   <= '0;
                    end
                end
                S_GRANT: begin
                    r_cnt <= r_cnt + TW'(1);
                    if (w_release) begin
                        r_pending[r_gidx] <= 1'b0;
                        r_rr_ptr          <= r_gidx + PW'(1);
                        r_grant           <= '0;
                        r_timeout         <= !w_done_hit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant_o      = r_grant;
    assign busy_o       = (r_state != S_IDLE);
    assign frame_done_o = (r_state == S_FINISH);
    assign timeout_o    = r_timeout;
    assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb_frame_update_scheduler
//   Timeline model: each planned frame is expanded into per-cycle expected
//   outputs (grant, busy, frame_done, timeout, overrun) and per-edge stimulus.
//   Cycle k is the interval after posedge k; inputs for edge k are driven at
//   the preceding negedge. Requester g raises done in its dly-th grant cycle
//   (counting from 0); dly >= TIMEOUT means it never answers.
module tb_frame_update_scheduler;

    localparam int N     = 4;
    localparam int T     = 64;
    localparam int MAXC  = 16384;
    localparam int NEVER = 1000;

    logic         clk, rst_n, frame_start_i;
    logic [N-1:0] req_i, done_i, grant_o;
    logic         busy_o, frame_done_o, timeout_o, overrun_o;

    frame_update_scheduler #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .TW(7)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start_i(frame_start_i),
        .req_i(req_i), .done_i(done_i), .grant_o(grant_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .timeout_o(timeout_o), .overrun_o(overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 0;
    int mrr   = 0;
    int mdly [N];

    logic [N-1:0] exp_grant [MAXC];
    bit           exp_busy  [MAXC];
    bit           exp_fd    [MAXC];
    bit           exp_to    [MAXC];
    bit           exp_ov    [MAXC];
    bit           drv_fs    [MAXC];
    logic [N-1:0] drv_req   [MAXC];
    logic [N-1:0] drv_done  [MAXC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic new_phase();
        for (int i = 0; i < MAXC; i++) begin
            exp_grant[i] = '0; exp_busy[i] = 0; exp_fd[i] = 0; exp_to[i] = 0;
            exp_ov[i] = 0; drv_fs[i] = 0; drv_req[i] = '0; drv_done[i] = '0;
        end
        cyc = 0;
        mrr = 0;
    endtask

    // Expand one frame starting at edge E with snapshot S into the timeline.
    task automatic plan_frame(input int E, input logic [N-1:0] S, output int F);
        int t, p, g, L;
        logic [N-1:0] pend;
        bit hit;
        drv_fs[E]  = 1;
        drv_req[E] = S;
        t = E;
        exp_busy[t] = 1;
        pend = S;
        p = mrr;
        while (pend != 0) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && pend[(p + k) % N]) g = (p + k) % N;
            hit = (mdly[g] < T);
            L = hit ? mdly[g] + 1 : T;
            for (int c = t + 1; c <= t + L; c++) begin
                exp_grant[c] = 4'b0001 << g;
                exp_busy[c]  = 1;
            end
            t = t + L + 1;
            exp_busy[t] = 1;
            if (hit) drv_done[t][g] = 1'b1;
            else     exp_to[t] = 1;
            pend[g] = 1'b0;
            p = (g + 1) % N;
        end
        mrr = p;
        exp_busy[t + 1] = 1;
        exp_fd[t + 1]   = 1;
        F = t + 1;
    endtask

    task automatic inject_ov(input int X);
        drv_fs[X] = 1;
        exp_ov[X] = 1;
    endtask

    task automatic apply(input int e);
        frame_start_i = drv_fs[e];
        req_i  = drv_fs[e] ? drv_req[e] : N'($urandom);
        // Noise on every done bit except the one the model says is granted.
        done_i = drv_done[e] | (N'($urandom) & ~exp_grant[e - 1]);
    endtask

    task automatic step();
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
        apply(cyc + 1);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic set_dly(input int d);
        for (int i = 0; i < N; i++) mdly[i] = d;
    endtask

    // Per-cycle comparison against the timeline.
    logic [N-1:0] seen, prev_g;
    always @(posedge clk) begin
        #1;
        if (!chk_en) begin
            seen   = '0;
            prev_g = '0;
        end else begin
            chk("grant_o",      grant_o,      exp_grant[cyc]);
            chk("busy_o",       busy_o,       exp_busy[cyc]);
            chk("frame_done_o", frame_done_o, exp_fd[cyc]);
            chk("timeout_o",    timeout_o,    exp_to[cyc]);
            chk("overrun_o",    overrun_o,    exp_ov[cyc]);
            chk("grant_onehot", $onehot0(grant_o), 1);
            if (grant_o != 0 && grant_o != prev_g) begin
                chk("regrant_in_frame", grant_o & seen, 0);
                seen = seen | grant_o;
            end
            if (frame_done_o) seen = '0;
            prev_g = grant_o;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    int E, F, X, cnt, r;
    logic [N-1:0] S;

    initial begin
        rst_n = 0; frame_start_i = 0; req_i = '0; done_i = '0;
        new_phase();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset grant_o", grant_o, 0);
        chk("reset busy_o", busy_o, 0);
        chk("reset frame_done_o", frame_done_o, 0);
        chk("reset timeout_o", timeout_o, 0);
        chk("reset overrun_o", overrun_o, 0);
        rst_n = 1;
        apply(1);
        chk_en = 1;

        // 1: req 1011, done 3 cycles into each grant.
        set_dly(3);
        E = cyc + 2;
        plan_frame(E, 4'b1011, F);
        chk("t1 model frame end", F - E, 16);
        chk("t1 model grant0", exp_grant[E + 1], 4'b0001);
        chk("t1 model gap", exp_grant[E + 5], 4'b0000);
        chk("t1 model grant1", exp_grant[E + 6], 4'b0010);
        chk("t1 model grant3", exp_grant[E + 11], 4'b1000);
        chk("t1 model rr", mrr, 0);
        run_to(F + 1);

        // 2: full request, then move rr to 2 and wrap.
        set_dly(1);
        E = cyc + 2;
        plan_frame(E, 4'b1111, F);
        chk("t2 model first", exp_grant[E + 1], 4'b0001);
        chk("t2 model last", exp_grant[E + 10], 4'b1000);
        run_to(F + 1);
        E = cyc + 2;
        plan_frame(E, 4'b0010, F);
        chk("t2 model rr", mrr, 2);
        run_to(F + 1);
        E = cyc + 2;
        plan_frame(E, 4'b1111, F);
        chk("t2 wrap g2", exp_grant[E + 1], 4'b0100);
        chk("t2 wrap g3", exp_grant[E + 4], 4'b1000);
        chk("t2 wrap g0", exp_grant[E + 7], 4'b0001);
        chk("t2 wrap g1", exp_grant[E + 10], 4'b0010);
        run_to(F + 1);

        // 3: silent grantee times out after exactly T grant cycles.
        set_dly(NEVER);
        E = cyc + 2;
        plan_frame(E, 4'b0100, F);
        cnt = 0;
        for (int c = E; c <= F; c++) if (exp_grant[c] == 4'b0100) cnt++;
        chk("t3 model grant length", cnt, 64);
        chk("t3 model timeout pulse", exp_to[F - 1], 1);
        run_to(F + 1);

        // 4: overrun mid-grant, then an empty frame.
        set_dly(5);
        E = cyc + 2;
        plan_frame(E, 4'b0011, F);
        inject_ov(E + 4);
        run_to(F + 1);
        E = cyc + 2;
        plan_frame(E, 4'b0000, F);
        chk("t4 model empty frame", F - E, 1);
        inject_ov(F + 1);
        run_to(F + 2);

        // 5: reset while grant 0010 is held.
        chk_en = 0;
        @(negedge clk);
        rst_n = 0; frame_start_i = 0; done_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        new_phase();
        apply(1);
        chk_en = 1;
        set_dly(NEVER);
        E = cyc + 2;
        plan_frame(E, 4'b0010, F);
        run_to(E + 5);
        chk_en = 0;
        chk("t5 grant before reset", grant_o, 4'b0010);
        #2 rst_n = 0;
        #1;
        chk("t5 async grant_o", grant_o, 0);
        chk("t5 async busy_o", busy_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        new_phase();
        apply(1);
        chk_en = 1;
        set_dly(2);
        E = cyc + 2;
        plan_frame(E, 4'b1111, F);
        chk("t5 model restart from 0", exp_grant[E + 1], 4'b0001);
        run_to(F + 1);

        // Random frames.
        for (int f = 0; f < 30; f++) begin
            S = N'($urandom);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 19);
                if (r < 12)       mdly[i] = $urandom_range(0, 6);
                else if (r < 17)  mdly[i] = $urandom_range(7, 20);
                else if (r == 17) mdly[i] = T - 1;
                else if (r == 18) mdly[i] = T - 2;
                else              mdly[i] = NEVER;
            end
            E = cyc + 2 + $urandom_range(0, 3);
            plan_frame(E, S, F);
            if ($urandom_range(0, 2) == 0) begin
                X = $urandom_range(E + 1, F + 1);
                inject_ov(X);
            end
            run_to(F + 1);
        end
        run_to(cyc + 4);
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
